// File: rtl/bayer_demosaic_pkg.sv
// Shared types for the Bayer binning block: CFA phase enum and quad-position colour lookup.
// Pure types/functions; no timing or flow control.
package bayer_pkg;

    typedef enum logic [1:0] {GRBG, RGGB, BGGR, GBRG} bayer_pattern_e;
    typedef enum logic [1:0] {COL_R, COL_G, COL_B} colour_e;

    // Colour of the raw site at parity (row0, col0) for a given CFA phase at (0,0).
    function automatic colour_e bayer_colour(input bayer_pattern_e pat, input logic row0, input logic col0);
        logic diag;
        colour_e c;
        diag = (row0 == col0);
        c = COL_G;
        case (pat)
            GRBG: c = diag ? COL_G : (row0 ? COL_B : COL_R);
            GBRG: c = diag ? COL_G : (row0 ? COL_R : COL_B);
            RGGB: c = diag ? (row0 ? COL_B : COL_R) : COL_G;
            BGGR: c = diag ? (row0 ? COL_R : COL_B) : COL_G;
            default: c = COL_G;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bayer_demosaic_if.sv
// Raw Bayer input stream plus binned RGB output stream of the demosaic block.
// master = camera/consumer side, slave = the demosaic block itself.
interface bayer_demosaic_if #(
    parameter int PIX_W = 12
);
    logic [PIX_W-1:0] iraw;
    logic             idval;
    logic             ifval;
    logic [PIX_W-1:0] ored;
    logic [PIX_W-1:0] ogreen;
    logic [PIX_W-1:0] oblue;
    logic             odval;

    modport master (
        output iraw, idval, ifval,
        input  ored, ogreen, oblue, odval
    );

    modport slave (
        input  iraw, idval, ifval,
        output ored, ogreen, oblue, odval
    );
endinterface

// File: rtl/bayer_demosaic_line_buffer.sv
// One-line raw sample store: synchronous write, combinational read, single clock.
// Latency 0 on read, write visible next clk; no backpressure.
module bayer_demosaic_line_buffer #(
    parameter int DEPTH = 1280,
    parameter int WIDTH = 12,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdat,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdat
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/bayer_demosaic.sv
// Bins each 2x2 Bayer quad of a raw stream into one RGB pixel (half width, half height).
// Latency 1 clk after the odd-row/odd-col beat; no backpressure, beats taken whenever idval && ifval.
module bayer_demosaic
    import bayer_pkg::*;
#(
    parameter int             IN_WIDTH  = 1280,
    parameter int             IN_HEIGHT = 960,
    parameter int             PIX_W     = 12,
    parameter bayer_pattern_e PATTERN   = GRBG
) (
    input  logic           clk,
    input  logic           rst,
    bayer_demosaic_if.slave bus
);

    localparam int COL_W = $clog2(IN_WIDTH);
    localparam int ROW_W = $clog2(IN_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_HEIGHT - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [PIX_W-1:0] r_q_tl;
    logic [PIX_W-1:0] r_q_bl;
    logic [PIX_W-1:0] r_red;
    logic [PIX_W-1:0] r_green;
    logic [PIX_W-1:0] r_blue;
    logic             r_odval;

    logic             w_acc;
    logic             w_quad_open;
    logic             w_quad_done;
    logic [PIX_W-1:0] w_above;
    logic [PIX_W-1:0] w_px [4];
    logic [PIX_W-1:0] w_red;
    logic [PIX_W-1:0] w_blue;
    logic [PIX_W:0]   w_gsum;

    assign w_acc       = bus.idval && bus.ifval;
    assign w_quad_open = w_acc && r_row[0] && !r_col[0];
    assign w_quad_done = w_acc && r_row[0] &&  r_col[0];

    // Raster position; blanking pins it at (0,0) so a dropped frame restarts cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (!bus.ifval) begin
            r_col <= '0;
            r_row <= '0;
        end else if (bus.idval) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Even rows fill the buffer, odd rows read the same column back as the sample above.
    bayer_demosaic_line_buffer #(
        .DEPTH (IN_WIDTH),
        .WIDTH (PIX_W)
    ) u_line_buffer (
        .clk     (clk),
        .i_we    (w_acc && !r_row[0]),
        .i_waddr (r_col),
        .i_wdat  (bus.iraw),
        .i_raddr (r_col),
        .o_rdat  (w_above)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_tl <= '0;
            r_q_bl <= '0;
        end else if (w_quad_open) begin
            r_q_tl <= w_above;
            r_q_bl <= bus.iraw;
        end
    end

    // Quad sites indexed {row parity, col parity}: 0=TL 1=TR 2=BL 3=BR.
    assign w_px[0] = r_q_tl;
    assign w_px[1] = w_above;
    assign w_px[2] = r_q_bl;
    assign w_px[3] = bus.iraw;

    always_comb begin
        w_red  = '0;
        w_blue = '0;
        w_gsum = '0;
        for (int p = 0; p < 4; p++) begin
            case (bayer_colour(PATTERN, p[1], p[0]))
                COL_R:   w_red  = w_px[p];
                COL_B:   w_blue = w_px[p];
                default: w_gsum = w_gsum + {1'b0, w_px[p]};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
            r_odval <= 1'b0;
        end else begin
            r_odval <= w_quad_done;
            if (w_quad_done) begin
                r_red   <= w_red;
                r_green <= w_gsum[PIX_W:1];
                r_blue  <= w_blue;
            end
        end
    end

    assign bus.ored   = r_red;
    assign bus.ogreen = r_green;
    assign bus.oblue  = r_blue;
    assign bus.odval  = r_odval;

endmodule
